// File: rtl/logic_clock_domain_crossing_async_write.sv
// Write-domain half of a dual-clock FIFO: gray pointer exchange, exact full via wrap bit, almost-full flag.
// Optional write_level register enabled by LOGIC_CLOCK_DOMAIN_CROSSING_ASYNC_WRITE_LEVEL_EN.
module logic_clock_domain_crossing_async_write #(
    parameter int DATA_WIDTH        = 1,
    parameter int ADDRESS_WIDTH     = 3,
    parameter int SYNC_STAGES       = 2,
    parameter int ALMOST_FULL_LEVEL = (2**ADDRESS_WIDTH) - 2
) (
    input  logic                     rx_aclk,
    input  logic                     rx_areset_n,
    input  logic                     rx_tvalid,
    input  logic [DATA_WIDTH-1:0]    rx_tdata,
    output logic                     rx_tready,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
    input  logic [ADDRESS_WIDTH:0]   read_pointer_gray,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH:0]   write_level
);
    localparam int PW = ADDRESS_WIDTH + 1;
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(ALMOST_FULL_LEVEL);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [PW-1:0]                  wptr_q, wptr_d;
    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  rptr_sync, used_next;
    logic                           accept;
    logic                           rx_tready_q, write_enable_q, almost_full_q;
    logic [ADDRESS_WIDTH-1:0]       write_address_q;
    logic [DATA_WIDTH-1:0]          write_data_q;
    logic [PW-1:0]                  wgray_q;

    always_comb begin
        accept    = rx_tvalid && rx_tready_q;
        wptr_d    = wptr_q + {{ADDRESS_WIDTH{1'b0}}, accept};
        rptr_sync = gray2bin(sync_q[SYNC_STAGES-1]);
        // Modular subtraction keeps occupancy correct across pointer wrap.
        used_next = wptr_d - rptr_sync;
    end

    always_ff @(posedge rx_aclk or negedge rx_areset_n) begin
        if (!rx_areset_n) begin
            sync_q          <= '0;
            wptr_q          <= '0;
            wgray_q         <= '0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            rx_tready_q     <= 1'b0;
            almost_full_q   <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], read_pointer_gray};
            wptr_q         <= wptr_d;
            // Gray follows wptr by one cycle so the read side never sees it ahead of the RAM write.
            wgray_q        <= wptr_q ^ (wptr_q >> 1);
            write_enable_q <= accept;
            if (accept) write_address_q <= wptr_q[ADDRESS_WIDTH-1:0];
            rx_tready_q    <= (used_next < DEPTH_P);
            almost_full_q  <= (used_next >= AF_P);
        end
    end

    always_ff @(posedge rx_aclk) begin
        if (accept) write_data_q <= rx_tdata;
    end

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ASYNC_WRITE_LEVEL_EN
    logic [PW-1:0] write_level_q;
    always_ff @(posedge rx_aclk or negedge rx_areset_n) begin
        if (!rx_areset_n) write_level_q <= '0;
        else              write_level_q <= used_next;
    end
    assign write_level = write_level_q;
`else
    assign write_level = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge rx_aclk) begin
        if (rx_areset_n) assert (used_next <= DEPTH_P) else $error("occupancy exceeds depth");
    end
`endif

    assign rx_tready          = rx_tready_q;
    assign write_enable       = write_enable_q;
    assign write_address      = write_address_q;
    assign write_data         = write_data_q;
    assign write_pointer_gray = wgray_q;
    assign almost_full        = almost_full_q;
endmodule

// File: tb/tb_logic_clock_domain_crossing_async_write.sv
// Directed bench for the FIFO write half; RAM writes checked against a scoreboard queue.
module tb_logic_clock_domain_crossing_async_write;
    logic       rx_aclk = 1'b0;
    logic       rx_areset_n;
    logic       rx_tvalid;
    logic [7:0] rx_tdata;
    logic       rx_tready;
    logic       write_enable;
    logic [2:0] write_address;
    logic [7:0] write_data;
    logic [3:0] write_pointer_gray;
    logic [3:0] read_pointer_gray;
    logic       almost_full;
    logic [3:0] write_level;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [2:0]  exp_wa = '0;
    logic [10:0] sb_q[$];
    logic [3:0]  prev_gray;

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ASYNC_WRITE_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic_clock_domain_crossing_async_write #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(3), .SYNC_STAGES(2), .ALMOST_FULL_LEVEL(6)
    ) dut (
        .rx_aclk(rx_aclk), .rx_areset_n(rx_areset_n), .rx_tvalid(rx_tvalid),
        .rx_tdata(rx_tdata), .rx_tready(rx_tready), .write_enable(write_enable),
        .write_address(write_address), .write_data(write_data),
        .write_pointer_gray(write_pointer_gray), .read_pointer_gray(read_pointer_gray),
        .almost_full(almost_full), .write_level(write_level)
    );

    always #5 rx_aclk = ~rx_aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] lvl(input int n);
        return LVL ? 32'(n) : 32'd0;
    endfunction

    // Handshake at each edge pushes the expected RAM write.
    always @(posedge rx_aclk) begin
        if (!rx_areset_n) begin
            sb_q.delete();
            exp_wa  <= '0;
            acc_cnt <= 0;
        end else if (rx_tvalid && rx_tready) begin
            sb_q.push_back({exp_wa, rx_tdata});
            exp_wa  <= exp_wa + 3'd1;
            acc_cnt <= acc_cnt + 1;
        end
    end

    always @(negedge rx_aclk) begin
        if (rx_areset_n) begin
            chk("write_enable", 32'(write_enable), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) begin
                logic [10:0] e;
                e = sb_q.pop_front();
                chk("write_address", 32'(write_address), 32'(e[10:8]));
                chk("write_data", 32'(write_data), 32'(e[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge rx_aclk);
        #1;
    endtask

    initial begin
        rx_areset_n = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata = '0;
        read_pointer_gray = '0;
        repeat (2) tick();
        chk("rst_tready", 32'(rx_tready), 0);
        chk("rst_we", 32'(write_enable), 0);
        chk("rst_wa", 32'(write_address), 0);
        chk("rst_gray", 32'(write_pointer_gray), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_level", 32'(write_level), 0);

        // Release and fill back-to-back.
        rx_areset_n = 1'b1;
        chk("tready_at_release", 32'(rx_tready), 0);
        rx_tvalid = 1'b1;
        tick();
        chk("tready_first_edge", 32'(rx_tready), 1);
        for (int i = 0; i < 8; i++) begin
            rx_tdata = 8'(i);
            tick();
            if (i == 4) begin
                chk("af_at5", 32'(almost_full), 0);
                chk("level_at5", 32'(write_level), lvl(5));
            end
            if (i == 5) chk("af_at6", 32'(almost_full), 1);
            if (i == 6) chk("tready_at7", 32'(rx_tready), 1);
        end
        chk("tready_full", 32'(rx_tready), 0);
        chk("level_full", 32'(write_level), lvl(8));
        rx_tdata = 8'hEE;
        tick();
        chk("gray_full", 32'(write_pointer_gray), 32'b1100);
        chk("tready_still_full", 32'(rx_tready), 0);

        // One read frees a slot after the synchroniser latency.
        read_pointer_gray = 4'b0001;
        tick();
        chk("tready_sync1", 32'(rx_tready), 0);
        tick();
        chk("tready_sync2", 32'(rx_tready), 0);
        tick();
        chk("tready_sync3", 32'(rx_tready), 1);
        chk("level_sync3", 32'(write_level), lvl(7));
        chk("af_sync3", 32'(almost_full), 1);
        rx_tdata = 8'h88;
        tick();
        chk("wa_after_full", 32'(write_address), 0);
        chk("wd_after_full", 32'(write_data), 32'h88);
        chk("tready_refull", 32'(rx_tready), 0);
        chk("level_refull", 32'(write_level), lvl(8));

        // Streaming with the reader two behind; pointers wrap.
        rx_tvalid = 1'b0;
        read_pointer_gray = b2g(4'(acc_cnt - 2));
        repeat (4) tick();
        chk("level_trail", 32'(write_level), lvl(2));
        chk("tready_trail", 32'(rx_tready), 1);
        prev_gray = write_pointer_gray;
        for (int i = 0; i < 20; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata = 8'(8'h10 + i);
            read_pointer_gray = b2g(4'(acc_cnt - 2));
            tick();
            chk("tready_stream", 32'(rx_tready), 1);
            if (i >= 1) chk("gray_one_bit", 32'($countones(write_pointer_gray ^ prev_gray)), 1);
            prev_gray = write_pointer_gray;
        end
        rx_tvalid = 1'b0;
        tick();
        chk("gray_after_wrap", 32'(write_pointer_gray), 32'b1011);

        // Drain, refill to 5, then reset mid-burst.
        read_pointer_gray = b2g(4'(acc_cnt));
        repeat (4) tick();
        chk("level_empty", 32'(write_level), lvl(0));
        chk("af_empty", 32'(almost_full), 0);
        for (int i = 0; i < 5; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata = 8'(8'h30 + i);
            tick();
        end
        chk("level_5", 32'(write_level), lvl(5));
        chk("af_5", 32'(almost_full), 0);
        #2;
        rx_areset_n = 1'b0;
        read_pointer_gray = '0;
        #1;
        chk("async_tready", 32'(rx_tready), 0);
        chk("async_we", 32'(write_enable), 0);
        chk("async_wa", 32'(write_address), 0);
        chk("async_gray", 32'(write_pointer_gray), 0);
        chk("async_af", 32'(almost_full), 0);
        chk("async_level", 32'(write_level), 0);
        repeat (2) tick();
        rx_areset_n = 1'b1;
        rx_tdata = 8'h5A;
        tick();
        chk("tready_rerelease", 32'(rx_tready), 1);
        tick();
        chk("wa_restart", 32'(write_address), 0);
        chk("wd_restart", 32'(write_data), 32'h5A);
        chk("we_restart", 32'(write_enable), 1);
        rx_tvalid = 1'b0;
        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
